i2c_target_lm75: RTL and testbench
==================================

Name: i2c_target_lm75

Overview:
- I2C target (slave) emulating an LM75 temperature sensor: the responder end of the bus that the i2cbus master sequencer polls.
- Used for on-FPGA loopback tests of the master, and for exposing an FPGA-side temperature or status word to an external I2C host.
- Supports the pointer register and the LM75 temp/config/thyst/tos registers, with clock-domain sampling of SCL/SDA via `clk`.

Parameters:
- ADDR, 7'h48, 7-bit target address matched on the bus.
- FILTER_LEN, 3, number of consecutive equal synchronized samples required before SCL/SDA filtered levels change.
- THYST_RESET, 16'h4B00, reset value of the thyst register (75 C).
- TOS_RESET, 16'h5000, reset value of the tos register (80 C).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL rate.
- rst  input  1  synchronous active-high reset.
- scl  input  1  I2C clock from master.
- sda  inout  1  I2C data; driven 0 or high-Z only, never driven 1.
- temp_in  input  16  temperature word returned for pointer 0.
- config_out  output  8  config register (pointer 1).
- thyst_out  output  16  thyst register (pointer 2).
- tos_out  output  16  tos register (pointer 3).
- rd_strobe  output  1  one-cycle pulse when temp_in is snapshotted for a read.
- wr_strobe  output  1  one-cycle pulse when a register write commits.

Behaviour:
- Reset values (clocked on `rst`=1):
  - sda released; state IDLE; pointer 0.
  - config_out 0; thyst_out THYST_RESET; tos_out TOS_RESET.
  - Strobes 0.
  - Reset mid-transfer: sda released the same cycle rst is sampled; no partial commit.
- Input conditioning: 2-flop sync on scl/sda, then a FILTER_LEN stability filter. Edge detection runs on the filtered levels.
- Bus events:
  - START: filtered sda falls while scl high.
  - STOP: filtered sda rises while scl high.
  - Repeated START in any state: go to ADDR, bit counter cleared, sda released.
  - STOP in any state: go to IDLE, sda released, uncommitted write bytes discarded.
- Bit timing:
  - Sample sda on scl rising edge, MSB first.
  - Change the sda drive only on scl falling edge (1 clk after the detected fall).
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits.
    - If addr[7:1]==ADDR: drive ACK for the 9th clock.
      - R/W=0 → PTR.
      - R/W=1 → snapshot temp_in if pointer==0, pulse rd_strobe, byte index=0 → RDATA.
    - Mismatch: release and go to IDLE; never ACK.
  - PTR: receive 8 bits. Pointer=byte[1:0]; bits [7:2] ignored. ACK → WDATA with byte index 0.
  - WDATA, 8-bit register (pointer 1):
    - Byte 0 commits to config_out at ACK; pulse wr_strobe.
    - Further bytes are ACKed and overwrite config again.
  - WDATA, 16-bit registers (pointers 2, 3):
    - Byte 0 is the MSB, held in a staging register.
    - Byte 1 (LSB) commits both bytes at ACK; pulse wr_strobe. Byte index wraps to 0.
  - WDATA, pointer 0 (read-only): bytes are ACKed and ignored; no strobe.
  - RDATA:
    - Shift out the selected register byte (MSB byte first; config returns the same byte every time).
    - Release sda during the master ACK bit and sample it.
    - Master ACK (0): continue with next byte. For 16-bit registers the byte index toggles, so a 3rd byte repeats the MSB.
    - Master NACK (1): release and wait for STOP/START (state WAIT).
  - Data for 16-bit reads comes from a snapshot latched at address match, keeping the word coherent across bytes.
- Simultaneous events:
  - rst has priority over all.
  - START/STOP detection has priority over bit shifting in the same cycle.
- wr_strobe and rd_strobe are never asserted in the same cycle.

Test Plan:
- Reset then idle bus → sda high-Z, config_out=00, thyst_out=4B00, tos_out=5000, strobes 0.
- temp_in=16'h1980; master writes 0x90,0x00 then repeated START 0x91, reads 2 bytes ACK/NACK → bytes 0x19,0x80; rd_strobe one pulse; target ACKs addr and pointer.
- Write 0x90,0x03,0x55,0x00 STOP → tos_out=5500 after LSB ACK, one wr_strobe; read back via pointer 3 gives 0x55,0x00,0x55 over 3 bytes.
- Address 0x92 (7'h49) → no ACK on 9th clock, state IDLE, all registers unchanged.
- Write 0x90,0x02,0x12 then STOP (LSB missing) → thyst_out stays 4B00, no wr_strobe.
- Assert rst during the 4th data bit of a read while the target drives sda low → sda released the next clk, config_out returns to 00, next transaction decodes normally.

Source files
------------

// File: rtl/i2c_target_lm75.sv
// i2c_target_lm75: I2C target that behaves like an LM75 temperature sensor.
// It exposes a pointer register plus the temp (read-only), config, thyst and
// tos registers. SCL/SDA are oversampled on clk, so clk must be well above
// the bus rate (8x or more).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus free or not addressed; waiting for START
// S_ADDR  | shifting in address + R/W, ACK on match
// S_PTR   | shifting in the pointer byte
// S_WDATA | shifting in register write bytes
// S_RDATA | shifting out register bytes, sampling master ACK/NACK
// S_WAIT  | master NACKed a read byte; waiting for STOP or START
module i2c_target_lm75 #(
  parameter logic [6:0]  ADDR        = 7'h48,
  parameter int          FILTER_LEN  = 3,
  parameter logic [15:0] THYST_RESET = 16'h4B00,
  parameter logic [15:0] TOS_RESET   = 16'h5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_in,
  output logic [7:0]  config_out,
  output logic [15:0] thyst_out,
  output logic [15:0] tos_out,
  output logic        rd_strobe,
  output logic        wr_strobe
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_PTR, S_WDATA, S_RDATA, S_WAIT
  } state_t;

  state_t          state;
  logic            scl_s1, scl_s2, sda_s1, sda_s2;
  logic            scl_f, sda_f, scl_d, sda_d;
  logic [CNT_W-1:0] scl_cnt, sda_cnt;
  logic            sda_oe;
  logic [3:0]      bit_cnt;
  logic            ack_phase;
  logic [7:0]      shift;
  logic [1:0]      ptr;
  logic            byte_idx;
  logic [7:0]      stage;
  logic [15:0]     snap;
  logic            master_nack;

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] tx_cur, tx_next;

  // Open-drain output: only ever pull low.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  // Byte to transmit for the current and the following read slot; config
  // repeats, 16-bit words alternate MSB/LSB out of the coherent snapshot.
  assign tx_cur  = (ptr == 2'd1) ? config_out : (byte_idx ? snap[7:0] : snap[15:8]);
  assign tx_next = (ptr == 2'd1) ? config_out : (byte_idx ? snap[15:8] : snap[7:0]);

  // Two-flop synchronizers, stability filters and delayed copies for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1  <= 1'b1;
      scl_s2  <= 1'b1;
      sda_s1  <= 1'b1;
      sda_s2  <= 1'b1;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      scl_d  <= scl_f;
      sda_d  <= sda_f;
      if (scl_s2 == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_LAST) begin
        scl_f   <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_s2 == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_LAST) begin
        sda_f   <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
    end
  end

  // Protocol FSM: bus events, bit shifting, ACK handling and register commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sda_oe      <= 1'b0;
      bit_cnt     <= 4'd0;
      ack_phase   <= 1'b0;
      shift       <= 8'h00;
      ptr         <= 2'd0;
      byte_idx    <= 1'b0;
      stage       <= 8'h00;
      snap        <= 16'h0000;
      master_nack <= 1'b0;
      config_out  <= 8'h00;
      thyst_out   <= THYST_RESET;
      tos_out     <= TOS_RESET;
      rd_strobe   <= 1'b0;
      wr_strobe   <= 1'b0;
    end else begin
      rd_strobe <= 1'b0;
      wr_strobe <= 1'b0;
      if (start_det) begin
        state     <= S_ADDR;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        // Resetting the byte index drops any staged MSB.
        state     <= S_IDLE;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        byte_idx  <= 1'b0;
      end else if (ack_phase) begin
        // End of our ACK clock: release, or start driving the first read byte.
        if (scl_fall) begin
          ack_phase <= 1'b0;
          bit_cnt   <= 4'd0;
          if (state == S_RDATA) begin
            shift  <= tx_cur;
            sda_oe <= ~tx_cur[7];
          end else begin
            sda_oe <= 1'b0;
          end
        end
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              ack_phase <= 1'b1;
              sda_oe    <= 1'b1;
              case (state)
                S_ADDR: begin
                  if (shift[7:1] == ADDR) begin
                    byte_idx <= 1'b0;
                    if (shift[0]) begin
                      state     <= S_RDATA;
                      rd_strobe <= (ptr == 2'd0);
                      case (ptr)
                        2'd0:    snap <= temp_in;
                        2'd1:    snap <= {config_out, config_out};
                        2'd2:    snap <= thyst_out;
                        default: snap <= tos_out;
                      endcase
                    end else begin
                      state <= S_PTR;
                    end
                  end else begin
                    state     <= S_IDLE;
                    ack_phase <= 1'b0;
                    sda_oe    <= 1'b0;
                  end
                end
                S_PTR: begin
                  ptr      <= shift[1:0];
                  byte_idx <= 1'b0;
                  state    <= S_WDATA;
                end
                default: begin
                  case (ptr)
                    2'd1: begin
                      config_out <= shift;
                      wr_strobe  <= 1'b1;
                    end
                    2'd2, 2'd3: begin
                      if (!byte_idx) begin
                        stage    <= shift;
                        byte_idx <= 1'b1;
                      end else begin
                        if (ptr == 2'd2) thyst_out <= {stage, shift};
                        else             tos_out   <= {stage, shift};
                        wr_strobe <= 1'b1;
                        byte_idx  <= 1'b0;
                      end
                    end
                    default: ;
                  endcase
                end
              endcase
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd8) begin
                master_nack <= sda_f;
                bit_cnt     <= 4'd9;
              end else if (bit_cnt < 4'd8) begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
              end else if (bit_cnt == 4'd9) begin
                if (master_nack) begin
                  state  <= S_WAIT;
                  sda_oe <= 1'b0;
                end else begin
                  if (ptr != 2'd1) byte_idx <= ~byte_idx;
                  shift   <= tx_next;
                  sda_oe  <= ~tx_next[7];
                  bit_cnt <= 4'd0;
                end
              end else if (bit_cnt != 4'd0) begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_lm75.sv
// Bench for i2c_target_lm75: bit-banged I2C master plus a byte-level
// register model of the LM75 target.
module tb_i2c_target_lm75;
  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl = 1'b1;
  logic        m_oe = 1'b0;
  logic [15:0] temp_in = 16'h0000;
  wire         sda;
  wire  [7:0]  config_out;
  wire  [15:0] thyst_out, tos_out;
  wire         rd_strobe, wr_strobe;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_target_lm75 dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .temp_in(temp_in),
    .config_out(config_out), .thyst_out(thyst_out), .tos_out(tos_out),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic both_seen = 1'b0;

  always @(posedge clk) begin
    if (wr_strobe) wr_cnt <= wr_cnt + 1;
    if (rd_strobe) rd_cnt <= rd_cnt + 1;
    if (wr_strobe && rd_strobe) both_seen <= 1'b1;
  end

  // Register model
  logic [7:0]  m_cfg;
  logic [15:0] m_thyst, m_tos;
  logic [1:0]  m_ptr;

  task automatic model_reset();
    m_cfg = 8'h00; m_thyst = 16'h4B00; m_tos = 16'h5000; m_ptr = 2'd0;
  endtask

  // Applies one write transaction (pointer byte then n data bytes, ended by STOP).
  task automatic model_write(input logic [7:0] p, input logic [7:0] d [4], input int n,
                             output int commits);
    logic [7:0] msb;
    int half;
    commits = 0; half = 0; msb = 8'h00;
    m_ptr = p[1:0];
    for (int i = 0; i < n; i++) begin
      if (m_ptr == 2'd1) begin
        m_cfg = d[i]; commits++;
      end else if (m_ptr != 2'd0) begin
        if (half == 0) begin
          msb = d[i]; half = 1;
        end else begin
          if (m_ptr == 2'd2) m_thyst = {msb, d[i]}; else m_tos = {msb, d[i]};
          commits++; half = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] model_read_byte(input int k, input logic [15:0] temp_snap);
    logic [15:0] w;
    if (m_ptr == 2'd1) return m_cfg;
    w = (m_ptr == 2'd0) ? temp_snap : (m_ptr == 2'd2) ? m_thyst : m_tos;
    return (k % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  // Bus master primitives
  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; wq(); scl = 1'b1; wq(); m_oe = 1'b1; wq(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; wq(); scl = 1'b1; wq(); m_oe = 1'b0; wq(); wq();
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    wq(); m_oe = ~b; wq(); scl = 1'b1; wq(); r = sda; wq(); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      d[i] = r;
    end
    xfer_bit(nack, r);
  endtask

  task automatic txn_write(input logic [7:0] p, input logic [7:0] d [4], input int n,
                           output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    write_byte(8'h90, a); if (!a) nacks++;
    write_byte(p, a);     if (!a) nacks++;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], a); if (!a) nacks++;
    end
    i2c_stop();
  endtask

  task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n,
                          input logic chg_temp, output logic [7:0] got [4], output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'h90, a); if (!a) nacks++;
      write_byte(p, a);     if (!a) nacks++;
      i2c_start();
    end
    write_byte(8'h91, a); if (!a) nacks++;
    for (int k = 0; k < n; k++) begin
      read_byte(k == n - 1, got[k]);
      if (chg_temp && k == 0) temp_in = 16'($urandom);
    end
    i2c_stop();
  endtask

  task automatic check_regs(input string tag);
    checks++;
    if (config_out !== m_cfg) begin
      failures++;
      $display("FAIL %s config_out: got %h expected %h", tag, config_out, m_cfg);
    end
    checks++;
    if (thyst_out !== m_thyst) begin
      failures++;
      $display("FAIL %s thyst_out: got %h expected %h", tag, thyst_out, m_thyst);
    end
    checks++;
    if (tos_out !== m_tos) begin
      failures++;
      $display("FAIL %s tos_out: got %h expected %h", tag, tos_out, m_tos);
    end
  endtask

  // Tests
  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_oe = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    model_reset();
    checks++;
    if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda: got %b expected 1", sda); end
    check_regs("reset");
    checks++;
    if (wr_cnt !== 0 || rd_cnt !== 0) begin
      failures++;
      $display("FAIL reset_strobes: got wr=%0d rd=%0d expected 0 0", wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_temp_read();
    logic [7:0] got [4];
    int nacks, rd0;
    temp_in = 16'h1980;
    rd0 = rd_cnt;
    txn_read(1'b1, 8'h00, 2, 1'b0, got, nacks);
    m_ptr = 2'd0;
    checks++;
    if (nacks !== 0) begin failures++; $display("FAIL temp_read_acks: got %0d nacks expected 0", nacks); end
    checks++;
    if (got[0] !== 8'h19 || got[1] !== 8'h80) begin
      failures++;
      $display("FAIL temp_read_data: got %h %h expected 19 80", got[0], got[1]);
    end
    checks++;
    if (rd_cnt - rd0 !== 1) begin failures++; $display("FAIL temp_read_strobe: got %0d expected 1", rd_cnt - rd0); end
  endtask

  task automatic test_tos_write_readback();
    logic [7:0] got [4];
    logic [7:0] d [4];
    logic a0, a1, a2, a3;
    int nacks, wr0, commits;
    wr0 = wr_cnt;
    i2c_start();
    write_byte(8'h90, a0); write_byte(8'h03, a1); write_byte(8'h55, a2); write_byte(8'h00, a3);
    d = '{8'h55, 8'h00, 8'h00, 8'h00};
    model_write(8'h03, d, 2, commits);
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111) begin failures++; $display("FAIL tos_write_acks: got %b expected 1111", {a0, a1, a2, a3}); end
    checks++;
    if (tos_out !== 16'h5500) begin failures++; $display("FAIL tos_after_lsb: got %h expected 5500", tos_out); end
    i2c_stop();
    checks++;
    if (wr_cnt - wr0 !== commits) begin failures++; $display("FAIL tos_wr_strobe: got %0d expected %0d", wr_cnt - wr0, commits); end
    check_regs("tos_write");
    txn_read(1'b1, 8'h03, 3, 1'b0, got, nacks);
    checks++;
    if (nacks !== 0 || got[0] !== 8'h55 || got[1] !== 8'h00 || got[2] !== 8'h55) begin
      failures++;
      $display("FAIL tos_readback: got %h %h %h nacks=%0d expected 55 00 55 nacks=0", got[0], got[1], got[2], nacks);
    end
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int wr0;
    wr0 = wr_cnt;
    i2c_start();
    write_byte(8'h92, a0);
    write_byte(8'h90, a1);
    i2c_stop();
    checks++;
    if (a0 !== 1'b0 || a1 !== 1'b0) begin failures++; $display("FAIL mismatch_ack: got %b%b expected 00", a0, a1); end
    checks++;
    if (sda !== 1'b1 || wr_cnt != wr0) begin failures++; $display("FAIL mismatch_bus: got sda=%b wr=%0d expected 1 0", sda, wr_cnt - wr0); end
    check_regs("mismatch");
  endtask

  task automatic test_partial_write();
    logic [7:0] d [4];
    int nacks, wr0, commits;
    wr0 = wr_cnt;
    d = '{8'h12, 8'h00, 8'h00, 8'h00};
    txn_write(8'h02, d, 1, nacks);
    model_write(8'h02, d, 1, commits);
    checks++;
    if (nacks !== 0 || wr_cnt - wr0 !== commits) begin
      failures++;
      $display("FAIL partial_write: got nacks=%0d wr=%0d expected 0 %0d", nacks, wr_cnt - wr0, commits);
    end
    check_regs("partial_write");
  endtask

  task automatic test_random();
    logic [7:0] got [4];
    logic [7:0] d [4];
    logic [7:0] p;
    logic [15:0] tsnap;
    int n, nacks, wr0, rd0, commits, op;
    for (int it = 0; it < 10; it++) begin
      op = $urandom_range(0, 2);
      p = 8'($urandom);
      if (op == 0) begin
        n = $urandom_range(0, 4);
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        wr0 = wr_cnt;
        txn_write(p, d, n, nacks);
        model_write(p, d, n, commits);
        checks++;
        if (nacks !== 0 || wr_cnt - wr0 !== commits) begin
          failures++;
          $display("FAIL rand_write it=%0d: got nacks=%0d wr=%0d expected 0 %0d", it, nacks, wr_cnt - wr0, commits);
        end
        check_regs("rand_write");
      end else begin
        n = $urandom_range(1, 4);
        temp_in = 16'($urandom);
        tsnap = temp_in;
        if (op == 1) m_ptr = p[1:0];
        rd0 = rd_cnt;
        txn_read(op == 1, p, n, 1'b1, got, nacks);
        checks++;
        if (nacks !== 0) begin failures++; $display("FAIL rand_read_acks it=%0d: got %0d expected 0", it, nacks); end
        checks++;
        if (rd_cnt - rd0 !== ((m_ptr == 2'd0) ? 1 : 0)) begin
          failures++;
          $display("FAIL rand_rd_strobe it=%0d: got %0d ptr=%0d", it, rd_cnt - rd0, m_ptr);
        end
        for (int k = 0; k < n; k++) begin
          checks++;
          if (got[k] !== model_read_byte(k, tsnap)) begin
            failures++;
            $display("FAIL rand_read it=%0d byte=%0d ptr=%0d: got %h expected %h", it, k, m_ptr, got[k], model_read_byte(k, tsnap));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] got [4];
    logic [7:0] d [4];
    logic a0, a1, a2;
    logic [2:0] bits;
    int nacks, commits;
    d = '{8'hA5, 8'h00, 8'h00, 8'h00};
    txn_write(8'h01, d, 1, nacks);
    model_write(8'h01, d, 1, commits);
    check_regs("pre_mid_reset");
    i2c_start();
    write_byte(8'h90, a0); write_byte(8'h01, a1);
    i2c_start();
    write_byte(8'h91, a2);
    for (int i = 2; i >= 0; i--) xfer_bit(1'b1, bits[i]);
    wq();
    checks++;
    if ({a0, a1, a2, bits, sda} !== 7'b1111010) begin
      failures++;
      $display("FAIL mid_read_setup: got %b expected 1111010", {a0, a1, a2, bits, sda});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sda !== 1'b1) begin failures++; $display("FAIL mid_reset_release: got %b expected 1", sda); end
    model_reset();
    check_regs("mid_reset");
    scl = 1'b1; m_oe = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    txn_write(8'h01, d, 1, nacks);
    model_write(8'h01, d, 1, commits);
    check_regs("post_reset");
    txn_read(1'b1, 8'h01, 2, 1'b0, got, nacks);
    checks++;
    if (nacks !== 0 || got[0] !== 8'h3C || got[1] !== 8'h3C) begin
      failures++;
      $display("FAIL post_reset_read: got %h %h nacks=%0d expected 3c 3c 0", got[0], got[1], nacks);
    end
  endtask

  initial begin
    test_reset();
    test_temp_read();
    test_tos_write_readback();
    test_addr_mismatch();
    test_partial_write();
    test_random();
    test_reset_mid_read();
    checks++;
    if (both_seen !== 1'b0) begin failures++; $display("FAIL strobe_overlap: got %b expected 0", both_seen); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
